alu_writeback: RTL

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback.sv | 105 ++++++++++
 1 files changed

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - two-entry ALU result writeback queue with commit routing and bypass
module alu_writeback (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_result,
  input  logic [2:0]  in_op,
  input  logic [3:0]  in_dest,
  input  logic        wb_stall,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [15:0] rf_wdata,
  output logic        pc_we,
  output logic [15:0] pc_wdata,
  output logic        fwd_valid,
  output logic [3:0]  fwd_dest,
  output logic [15:0] fwd_data,
  output logic [15:0] retired
);

  // Ops 101, 110 and 111 load the program counter instead of a register.
  function automatic logic is_pc_op(input logic [2:0] op);
    return op[2] & (op[1] | op[0]);
  endfunction

  logic [15:0] mem_result [2];
  logic [2:0]  mem_op     [2];
  logic [3:0]  mem_dest   [2];

  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;
  logic       newest;

  // Ready depends only on the registered occupancy, so a pop in the same
  // cycle never opens a slot for a push when the queue is full.
  assign in_ready = (count != 2'd2);
  assign push     = in_valid && in_ready;
  assign pop      = (count != 2'd0) && !wb_stall;
  assign newest   = ~wr_ptr;

  // Entry storage; contents are only observed through count-qualified paths.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_result[wr_ptr] <= in_result;
      mem_op[wr_ptr]     <= in_op;
      mem_dest[wr_ptr]   <= in_dest;
    end
  end

  // Queue pointers, occupancy, retire counter and registered commit strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      retired  <= 16'd0;
      rf_we    <= 1'b0;
      rf_waddr <= 4'd0;
      rf_wdata <= 16'd0;
      pc_we    <= 1'b0;
      pc_wdata <= 16'd0;
    end else begin
      rf_we <= 1'b0;
      pc_we <= 1'b0;
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        retired <= retired + 16'd1;
        if (is_pc_op(mem_op[rd_ptr])) begin
          pc_we    <= 1'b1;
          pc_wdata <= mem_result[rd_ptr];
        end else begin
          // r0 is hardwired to zero: the entry retires without a write strobe.
          rf_we    <= (mem_dest[rd_ptr] != 4'd0);
          rf_waddr <= mem_dest[rd_ptr];
          rf_wdata <= mem_result[rd_ptr];
        end
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Bypass the youngest queued entry when it will write a real register.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_dest  = 4'd0;
    fwd_data  = 16'd0;
    if ((count != 2'd0) && !is_pc_op(mem_op[newest]) && (mem_dest[newest] != 4'd0)) begin
      fwd_valid = 1'b1;
      fwd_dest  = mem_dest[newest];
      fwd_data  = mem_result[newest];
    end
  end

endmodule
